// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared definitions for the ALU issue/capture stage: datapath width, the
// 4-bit ALU opcode encoding (names match the ALU itself), and the MIPS
// primary opcode / R-type funct values recognised by the decoder.
// No ports; imported by alu_issue_decode and alu_issue_stage.
package alu_issue_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    AND          = 4'b0000,
    OR           = 4'b0001,
    ADD          = 4'b0010,
    LF_16        = 4'b0011,
    UNSIGNED_SLT = 4'b0100,
    SLL          = 4'b0101,
    SUB          = 4'b0110,
    SIGNED_SLT   = 4'b0111,
    NOR          = 4'b1001,
    XOR          = 4'b1010,
    SRA          = 4'b1011,
    SRL          = 4'b1100
  } alu_op_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode
// Purely combinational decoder: turns a MIPS instruction plus its rs/rt
// operand values into the ALU opcode, A/B operands, destination register,
// write enable and an illegal-instruction flag.
// Ports:
//   instr   in  32  instruction word
//   rs_val  in  DW  value of register rs
//   rt_val  in  DW  value of register rt
//   op      out 4   ALU opcode
//   a, b    out DW  ALU operands
//   dest    out 5   destination register index
//   we      out 1   register write enable (legal and dest != 0)
//   illegal out 1   instruction outside the decode set
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output alu_op_t               op,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [4:0]            dest,
  output logic                  we,
  output logic                  illegal
);

  logic [5:0]            opcode;
  logic [4:0]            rt_idx;
  logic [4:0]            rd_idx;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] shamt_ext;
  logic                  legal;

  // rs index (instr[25:21]) only matters through rs_val, so it is not split out
  assign opcode    = instr[31:26];
  assign rt_idx    = instr[20:16];
  assign rd_idx    = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  assign imm_sext  = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zext  = {{(DATA_WIDTH-16){1'b0}}, imm};
  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, shamt};

  // Field selection per instruction class; anything unrecognised collapses
  // to a harmless AND of zeros with no destination.
  always_comb begin
    op    = AND;
    a     = '0;
    b     = '0;
    dest  = '0;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        dest  = rd_idx;
        b     = rt_val;
        a     = rs_val;
        case (funct)
          FN_SLL:          begin op = SLL; a = shamt_ext; end
          FN_SRL:          begin op = SRL; a = shamt_ext; end
          FN_SRA:          begin op = SRA; a = shamt_ext; end
          FN_SLLV:         op = SLL;
          FN_SRLV:         op = SRL;
          FN_SRAV:         op = SRA;
          FN_ADD, FN_ADDU: op = ADD;
          FN_SUB, FN_SUBU: op = SUB;
          FN_AND:          op = AND;
          FN_OR:           op = OR;
          FN_XOR:          op = XOR;
          FN_NOR:          op = NOR;
          FN_SLT:          op = SIGNED_SLT;
          FN_SLTU:         op = UNSIGNED_SLT;
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin legal = 1'b1; op = ADD;          a = rs_val; b = imm_sext; dest = rt_idx; end
      OP_SLTI:           begin legal = 1'b1; op = SIGNED_SLT;   a = rs_val; b = imm_sext; dest = rt_idx; end
      OP_SLTIU:          begin legal = 1'b1; op = UNSIGNED_SLT; a = rs_val; b = imm_sext; dest = rt_idx; end
      OP_ANDI:           begin legal = 1'b1; op = AND;          a = rs_val; b = imm_zext; dest = rt_idx; end
      OP_ORI:            begin legal = 1'b1; op = OR;           a = rs_val; b = imm_zext; dest = rt_idx; end
      OP_XORI:           begin legal = 1'b1; op = XOR;          a = rs_val; b = imm_zext; dest = rt_idx; end
      // The ALU itself moves B[15:0] into the upper half for LUI
      OP_LUI:            begin legal = 1'b1; op = LF_16;        a = '0;     b = imm_zext; dest = rt_idx; end
      default:           legal = 1'b0;
    endcase
    if (!legal) begin
      op   = AND;
      a    = '0;
      b    = '0;
      dest = '0;
    end
  end

  assign we      = legal && (dest != 5'd0);
  assign illegal = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Two-register issue/capture stage in front of the ALU. An accepted
// instruction is decoded into the EX register (which drives the ALU), and
// the ALU's combinational result is captured into the WB register together
// with its destination, write enable and illegal flag.
// Optional feature macro: ALU_BYPASS_EN -- forwards in-flight results
// (EX entry first, then WB entry) onto rs/rt at accept time.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake
//   in_instr, in_rs_val/rt_val  instruction and register-file operands
//   alu_a, alu_b, alu_op        ALU inputs (EX register)
//   alu_result                  combinational ALU output
//   out_valid/out_ready         downstream handshake
//   out_result, out_dest,
//   out_we, out_illegal         captured writeback entry (WB register)
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs_val,
  input  logic [DATA_WIDTH-1:0] in_rt_val,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_dest,
  output logic                  out_we,
  output logic                  out_illegal
);

  logic                  ex_valid;
  logic [4:0]            ex_dest;
  logic                  ex_we;
  logic                  ex_illegal;

  logic                  w_ready;
  logic                  ex_ready;
  logic                  accept;
  logic                  advance;

  logic [DATA_WIDTH-1:0] rs_eff;
  logic [DATA_WIDTH-1:0] rt_eff;

  alu_op_t               dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [4:0]            dec_dest;
  logic                  dec_we;
  logic                  dec_illegal;

  // A stage can take new data when it is empty or its occupant leaves this
  // cycle, so a full pipeline still streams one instruction per cycle.
  assign w_ready  = !out_valid || out_ready;
  assign ex_ready = !ex_valid || w_ready;
  assign in_ready = ex_ready;
  assign accept   = in_valid && ex_ready;
  assign advance  = ex_valid && w_ready;

`ifdef ALU_BYPASS_EN
  logic [4:0] rs_idx;
  logic [4:0] rt_idx;

  assign rs_idx = in_instr[25:21];
  assign rt_idx = in_instr[20:16];

  // The youngest producer wins: the EX entry's result is still on the ALU
  // output, the older WB entry is in out_result. $0 is never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [4:0]            idx,
    input logic [DATA_WIDTH-1:0] rf_val,
    input logic                  exv,
    input logic                  exw,
    input logic [4:0]            exd,
    input logic [DATA_WIDTH-1:0] exr,
    input logic                  wbv,
    input logic                  wbw,
    input logic [4:0]            wbd,
    input logic [DATA_WIDTH-1:0] wbr
  );
    logic [DATA_WIDTH-1:0] val;
    val = rf_val;
    if (idx != 5'd0) begin
      if (exv && exw && (exd == idx)) begin
        val = exr;
      end else if (wbv && wbw && (wbd == idx)) begin
        val = wbr;
      end
    end
    return val;
  endfunction

  assign rs_eff = fwd(rs_idx, in_rs_val, ex_valid, ex_we, ex_dest, alu_result,
                      out_valid, out_we, out_dest, out_result);
  assign rt_eff = fwd(rt_idx, in_rt_val, ex_valid, ex_we, ex_dest, alu_result,
                      out_valid, out_we, out_dest, out_result);
`else
  assign rs_eff = in_rs_val;
  assign rt_eff = in_rt_val;
`endif

  alu_issue_decode u_decode (
    .instr   (in_instr),
    .rs_val  (rs_eff),
    .rt_val  (rt_eff),
    .op      (dec_op),
    .a       (dec_a),
    .b       (dec_b),
    .dest    (dec_dest),
    .we      (dec_we),
    .illegal (dec_illegal)
  );

  // EX register: data fields load only on accept so the ALU inputs stay
  // quiet while the stage is empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= AND;
      ex_dest    <= '0;
      ex_we      <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      alu_a      <= dec_a;
      alu_b      <= dec_b;
      alu_op     <= dec_op;
      ex_dest    <= dec_dest;
      ex_we      <= dec_we;
      ex_illegal <= dec_illegal;
    end else if (advance) begin
      ex_valid   <= 1'b0;
    end
  end

  // WB register: capture the ALU output as the EX entry moves on; a pop and
  // a push in the same cycle simply replace the entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_dest    <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (advance) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_dest    <= ex_dest;
      out_we      <= ex_we;
      out_illegal <= ex_illegal;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage with a behavioural ALU closing
// the loop from alu_a/alu_b/alu_op back to alu_result.
module tb_alu_issue_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_we;
  logic        out_illegal;

  int n_compared = 0;
  int n_mismatched = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dest    (out_dest),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU using the shared opcode encoding
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0011: alu_result = {alu_b[15:0], 16'h0000};
      4'b0100: alu_result = {31'b0, (alu_a < alu_b)};
      4'b0101: alu_result = alu_b << alu_a[4:0];
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      4'b1001: alu_result = ~(alu_a | alu_b);
      4'b1010: alu_result = alu_a ^ alu_b;
      4'b1011: alu_result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
      4'b1100: alu_result = alu_b >> alu_a[4:0];
      default: alu_result = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_result;
    logic [4:0]  exp_dest;
    logic        exp_we;
    logic        exp_illegal;
  } vector_t;

  localparam int NVEC = 18;
  vector_t vecs[NVEC];

  // Compare one value and log any difference
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one vector alone, check the EX view one edge later and the WB
  // view one further edge later, then let it drain.
  task automatic applyStimulus(input int i);
    @(negedge clk);
    in_instr  = vecs[i].instr;
    in_rs_val = vecs[i].rs_val;
    in_rt_val = vecs[i].rt_val;
    in_valid  = 1'b1;
    #1;
    checkOutput($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput($sformatf("v%0d alu_op", i), {28'b0, alu_op}, {28'b0, vecs[i].exp_op});
    checkOutput($sformatf("v%0d alu_a", i), alu_a, vecs[i].exp_a);
    checkOutput($sformatf("v%0d alu_b", i), alu_b, vecs[i].exp_b);
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
    checkOutput($sformatf("v%0d out_result", i), out_result, vecs[i].exp_result);
    checkOutput($sformatf("v%0d out_dest", i), {27'b0, out_dest}, {27'b0, vecs[i].exp_dest});
    checkOutput($sformatf("v%0d out_we", i), {31'b0, out_we}, {31'b0, vecs[i].exp_we});
    checkOutput($sformatf("v%0d out_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].exp_illegal});
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d drained", i), {31'b0, out_valid}, 32'd0);
  endtask

  logic [31:0] rx[4];
  int          rx_cyc[4];
  int          acc;
  int          got;
  logic        hs;
  logic        pop;
  logic        seen_out;
  logic [31:0] exp_byp;

  initial begin
    //          instr          rs            rt            op     a             b             result        dst we ill
    vecs[0]  = '{32'h2402FFFF, 32'h00000000, 32'h00000000, 4'h2, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  1'b1, 1'b0};
    vecs[1]  = '{32'h00041903, 32'h00000000, 32'h80000000, 4'hB, 32'h00000004, 32'h80000000, 32'hF8000000, 5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'h3C051234, 32'h0000DEAD, 32'h00000000, 4'h3, 32'h00000000, 32'h00001234, 32'h12340000, 5'd5,  1'b1, 1'b0};
    vecs[3]  = '{32'h342000F0, 32'h0F00000F, 32'h00000000, 4'h1, 32'h0F00000F, 32'h000000F0, 32'h0F0000FF, 5'd0,  1'b0, 1'b0};
    vecs[4]  = '{32'hFC000000, 32'h12345678, 32'h9ABCDEF0, 4'h0, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1};
    vecs[5]  = '{32'h00E83023, 32'h0000000A, 32'h00000003, 4'h6, 32'h0000000A, 32'h00000003, 32'h00000007, 5'd6,  1'b1, 1'b0};
    vecs[6]  = '{32'h014B482A, 32'hFFFFFFFF, 32'h00000001, 4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'd9,  1'b1, 1'b0};
    vecs[7]  = '{32'h014B482B, 32'hFFFFFFFF, 32'h00000001, 4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd9,  1'b1, 1'b0};
    vecs[8]  = '{32'h29ACFFFE, 32'hFFFFFFFD, 32'h00000000, 4'h7, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000001, 5'd12, 1'b1, 1'b0};
    vecs[9]  = '{32'h2DACFFFE, 32'h00000005, 32'h00000000, 4'h4, 32'h00000005, 32'hFFFFFFFE, 32'h00000001, 5'd12, 1'b1, 1'b0};
    vecs[10] = '{32'h31EE8001, 32'hFFFFFFFF, 32'h00000000, 4'h0, 32'hFFFFFFFF, 32'h00008001, 32'h00008001, 5'd14, 1'b1, 1'b0};
    vecs[11] = '{32'h3A30FFFF, 32'h12345678, 32'h00000000, 4'hA, 32'h12345678, 32'h0000FFFF, 32'h1234A987, 5'd16, 1'b1, 1'b0};
    vecs[12] = '{32'h02749027, 32'hF0F0F0F0, 32'h0F0F0000, 4'h9, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 5'd18, 1'b1, 1'b0};
    vecs[13] = '{32'h02D7A804, 32'h00000024, 32'h00000001, 4'h5, 32'h00000024, 32'h00000001, 32'h00000010, 5'd21, 1'b1, 1'b0};
    vecs[14] = '{32'h00020A02, 32'h00000000, 32'h80000000, 4'hC, 32'h00000008, 32'h80000000, 32'h00800000, 5'd1,  1'b1, 1'b0};
    vecs[15] = '{32'h00851820, 32'h7FFFFFFF, 32'h00000001, 4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'd3,  1'b1, 1'b0};
    vecs[16] = '{32'h00851801, 32'h7FFFFFFF, 32'h00000001, 4'h0, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1};
    vecs[17] = '{32'h00851825, 32'h000000F0, 32'h0000000F, 4'h1, 32'h000000F0, 32'h0000000F, 32'h000000FF, 5'd3,  1'b1, 1'b0};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_rs_val = 32'h0;
    in_rt_val = 32'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst alu_op", {28'b0, alu_op}, 32'd0);
    checkOutput("rst alu_a", alu_a, 32'd0);
    checkOutput("rst alu_b", alu_b, 32'd0);
    checkOutput("rst out_result", out_result, 32'd0);
    checkOutput("rst out_dest", {27'b0, out_dest}, 32'd0);
    checkOutput("rst out_we", {31'b0, out_we}, 32'd0);
    checkOutput("rst out_illegal", {31'b0, out_illegal}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i);
    end

    // Stream addiu $k,$0,k for k=1..4 with out_ready low for 3 cycles
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (acc < 4);
      in_instr  = (acc < 4) ? (32'h24000000 | (32'(acc + 1) << 16) | 32'(acc + 1)) : 32'h0;
      in_rs_val = 32'h0;
      in_rt_val = 32'h0;
      #1;
      if (cyc == 2) begin
        checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("stall accepted", 32'(acc), 32'd2);
        checkOutput("stall out_result", out_result, 32'd1);
      end
      hs  = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        if (got < 4) begin
          rx[got]     = out_result;
          rx_cyc[got] = cyc;
        end
        got++;
      end
      @(posedge clk);
      if (hs) acc++;
    end
    in_valid = 1'b0;
    checkOutput("stream count", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got) begin
        checkOutput($sformatf("stream result %0d", k), rx[k], 32'(k + 1));
        checkOutput($sformatf("stream cycle %0d", k), 32'(rx_cyc[k]), 32'(k + 3));
      end
    end

    // Reset while both stages hold an entry
    @(negedge clk);
    out_ready = 1'b0;
    in_instr  = 32'h24070007;
    in_valid  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("midrst full out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("midrst full in_ready", {31'b0, in_ready}, 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("midrst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrst alu_op", {28'b0, alu_op}, 32'd0);
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;
    seen_out  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen_out = 1'b1;
    end
    checkOutput("midrst no output", {31'b0, seen_out}, 32'd0);

    // Dependent pair: addiu $1,$0,5 then addu $2,$1,$1 with stale operands
`ifdef ALU_BYPASS_EN
    exp_byp = 32'd10;
`else
    exp_byp = 32'd0;
`endif
    @(negedge clk);
    in_instr  = 32'h24010005;
    in_rs_val = 32'h0;
    in_rt_val = 32'h0;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_instr = 32'h00211021;
    #1;
    checkOutput("bypass in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bypass alu_a", alu_a, exp_byp >> 1);
    checkOutput("bypass alu_b", alu_b, exp_byp >> 1);
    @(posedge clk);
    #1;
    checkOutput("bypass out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bypass out_result", out_result, exp_byp);
    checkOutput("bypass out_dest", {27'b0, out_dest}, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("bypass drained", {31'b0, out_valid}, 32'd0);
    checkOutput("idle alu_a hold", alu_a, exp_byp >> 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
